// File: rtl/mmc1_write_sequencer_if.sv
// Request handshake, MMC1 CPU-side bus pins and shadow-register readback
// bundled for the MMC1 write sequencer.
interface mmc1_write_sequencer_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_REG;
  logic [4:0] REQ_DATA;
  logic       BUS_A14;
  logic       BUS_A13;
  logic       BUS_D0;
  logic       BUS_D7;
  logic       nBUS_ROMSEL;
  logic       nBUS_RW;
  logic       BUSY;
  logic       DONE;
  logic [4:0] SH_CONTROL;
  logic [4:0] SH_CHR0;
  logic [4:0] SH_CHR1;
  logic [4:0] SH_PRG;

  // Sequencer side: accepts requests, masters the cartridge bus.
  modport master (
    input  REQ_VALID, REQ_REG, REQ_DATA,
    output REQ_READY, BUS_A14, BUS_A13, BUS_D0, BUS_D7, nBUS_ROMSEL, nBUS_RW,
    output BUSY, DONE, SH_CONTROL, SH_CHR0, SH_CHR1, SH_PRG
  );

  // Host side: issues requests, observes the bus and shadows.
  modport slave (
    output REQ_VALID, REQ_REG, REQ_DATA,
    input  REQ_READY, BUS_A14, BUS_A13, BUS_D0, BUS_D7, nBUS_ROMSEL, nBUS_RW,
    input  BUSY, DONE, SH_CONTROL, SH_CHR0, SH_CHR1, SH_PRG
  );
endinterface

// File: rtl/mmc1_write_sequencer.sv
// MMC1 write sequencer: turns one parallel 5-bit register load into an
// optional D7 shift-register reset write followed by five serial D0 writes
// (LSB first), and keeps shadow copies of the four MMC1 registers.
// All outputs are registered; they are decoded from the state being entered.
module mmc1_write_sequencer #(
  parameter int GAP_CYCLES  = 1,
  parameter bit RESET_FIRST = 1'b1
) (
  input logic                    CPU_M2,
  input logic                    nRESET,
  mmc1_write_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RST_SETUP, RST_STROBE, BIT_SETUP, BIT_STROBE, GAP
  } state_t;

  localparam logic [3:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [4:0] CTRL_RESET = 5'b01100;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [3:0] gap_reg, gap_next;
  logic [1:0] sel_reg, sel_next;
  logic [4:0] data_reg, data_next;
  logic       from_rst_reg, from_rst_next;   // current GAP follows the reset write
  logic       finish, ctrl_or;

  logic       ready_reg, busy_reg, done_reg;
  logic       a14_reg, a13_reg, d0_reg, d7_reg, romsel_reg, rw_reg;
  logic       a14_next, a13_next, d0_next, d7_next, romsel_next, rw_next;
  logic [4:0] sh_control_reg, sh_chr0_reg, sh_chr1_reg, sh_prg_reg;

  // State register.
  always_ff @(posedge CPU_M2) begin
    if (!nRESET) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic, request latching, bit index and gap counting.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    gap_next      = gap_reg;
    sel_next      = sel_reg;
    data_next     = data_reg;
    from_rst_next = from_rst_reg;
    finish        = 1'b0;
    ctrl_or       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.REQ_VALID && ready_reg) begin
          sel_next      = bus.REQ_REG;
          data_next     = bus.REQ_DATA;
          idx_next      = 3'd0;
          from_rst_next = 1'b0;
          state_next    = RESET_FIRST ? RST_SETUP : BIT_SETUP;
        end
      end
      RST_SETUP: state_next = RST_STROBE;
      RST_STROBE: begin
        ctrl_or       = 1'b1;
        from_rst_next = 1'b1;
        if (GAP_CYCLES == 0) begin
          state_next = BIT_SETUP;
        end else begin
          state_next = GAP;
          gap_next   = GAP_LOAD;
        end
      end
      BIT_SETUP: state_next = BIT_STROBE;
      BIT_STROBE: begin
        from_rst_next = 1'b0;
        if (GAP_CYCLES != 0) begin
          state_next = GAP;
          gap_next   = GAP_LOAD;
        end else if (idx_reg == 3'd4) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = BIT_SETUP;
        end
      end
      GAP: begin
        if (gap_reg != 4'd0) begin
          gap_next = gap_reg - 4'd1;
        end else if (from_rst_reg) begin
          state_next = BIT_SETUP;
        end else if (idx_reg == 3'd4) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = BIT_SETUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus pin values for the state being entered.
  always_comb begin
    a14_next    = 1'b0;
    a13_next    = 1'b0;
    d0_next     = 1'b0;
    d7_next     = 1'b0;
    romsel_next = 1'b1;
    rw_next     = 1'b1;
    if (state_next != IDLE) begin
      a14_next = sel_next[1];
      a13_next = sel_next[0];
    end
    unique case (state_next)
      RST_SETUP:  d7_next = 1'b1;
      RST_STROBE: begin
        d7_next     = 1'b1;
        romsel_next = 1'b0;
        rw_next     = 1'b0;
      end
      BIT_SETUP:  d0_next = data_next[idx_next];
      BIT_STROBE: begin
        d0_next     = data_next[idx_next];
        romsel_next = 1'b0;
        rw_next     = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath, registered outputs and shadow registers.
  always_ff @(posedge CPU_M2) begin
    if (!nRESET) begin
      idx_reg        <= 3'd0;
      gap_reg        <= 4'd0;
      sel_reg        <= 2'd0;
      data_reg       <= 5'd0;
      from_rst_reg   <= 1'b0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      a14_reg        <= 1'b0;
      a13_reg        <= 1'b0;
      d0_reg         <= 1'b0;
      d7_reg         <= 1'b0;
      romsel_reg     <= 1'b1;
      rw_reg         <= 1'b1;
      sh_control_reg <= CTRL_RESET;
      sh_chr0_reg    <= 5'd0;
      sh_chr1_reg    <= 5'd0;
      sh_prg_reg     <= 5'd0;
    end else begin
      idx_reg      <= idx_next;
      gap_reg      <= gap_next;
      sel_reg      <= sel_next;
      data_reg     <= data_next;
      from_rst_reg <= from_rst_next;
      ready_reg    <= (state_next == IDLE);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= finish;
      a14_reg      <= a14_next;
      a13_reg      <= a13_next;
      d0_reg       <= d0_next;
      d7_reg       <= d7_next;
      romsel_reg   <= romsel_next;
      rw_reg       <= rw_next;
      // A reset write on real MMC1 hardware also forces PRG mode 3.
      if (ctrl_or) sh_control_reg <= sh_control_reg | CTRL_RESET;
      if (finish) begin
        unique case (sel_reg)
          2'b00: sh_control_reg <= data_reg;
          2'b01: sh_chr0_reg    <= data_reg;
          2'b10: sh_chr1_reg    <= data_reg;
          default: sh_prg_reg   <= data_reg;
        endcase
      end
    end
  end

  assign bus.REQ_READY   = ready_reg;
  assign bus.BUSY        = busy_reg;
  assign bus.DONE        = done_reg;
  assign bus.BUS_A14     = a14_reg;
  assign bus.BUS_A13     = a13_reg;
  assign bus.BUS_D0      = d0_reg;
  assign bus.BUS_D7      = d7_reg;
  assign bus.nBUS_ROMSEL = romsel_reg;
  assign bus.nBUS_RW     = rw_reg;
  assign bus.SH_CONTROL  = sh_control_reg;
  assign bus.SH_CHR0     = sh_chr0_reg;
  assign bus.SH_CHR1     = sh_chr1_reg;
  assign bus.SH_PRG      = sh_prg_reg;

endmodule

// File: tb/tb_mmc1_write_sequencer.sv
// Testbench for mmc1_write_sequencer: two instances (defaults, and
// GAP_CYCLES=0/RESET_FIRST=0) driven by directed and random requests,
// checked against a transaction-level model of the serial protocol.
module tb_mmc1_write_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0] req_reg = 2'd0;
  logic [4:0] req_data = 5'd0;

  typedef struct {
    int   cyc;
    logic d7;
    logic d0;
    logic a14;
    logic a13;
  } strobe_t;

  strobe_t    qa[$];
  strobe_t    qb[$];
  int         last_strobe[2];
  logic [4:0] sh_model[2][4];

  mmc1_write_sequencer_if bus_a ();
  mmc1_write_sequencer_if bus_b ();

  assign bus_a.REQ_VALID = valid_a;
  assign bus_a.REQ_REG   = req_reg;
  assign bus_a.REQ_DATA  = req_data;
  assign bus_b.REQ_VALID = valid_b;
  assign bus_b.REQ_REG   = req_reg;
  assign bus_b.REQ_DATA  = req_data;

  mmc1_write_sequencer #(.GAP_CYCLES(1), .RESET_FIRST(1'b1)) u_dut_a (
    .CPU_M2(clk), .nRESET(rst_n), .bus(bus_a));
  mmc1_write_sequencer #(.GAP_CYCLES(0), .RESET_FIRST(1'b0)) u_dut_b (
    .CPU_M2(clk), .nRESET(rst_n), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus_b.REQ_READY : bus_a.REQ_READY;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? bus_b.DONE : bus_a.DONE;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? bus_b.BUSY : bus_a.BUSY;
  endfunction
  function automatic logic [4:0] get_sh(input bit sel, input int r);
    logic [4:0] v;
    case (r)
      0: v = sel ? bus_b.SH_CONTROL : bus_a.SH_CONTROL;
      1: v = sel ? bus_b.SH_CHR0    : bus_a.SH_CHR0;
      2: v = sel ? bus_b.SH_CHR1    : bus_a.SH_CHR1;
      default: v = sel ? bus_b.SH_PRG : bus_a.SH_PRG;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      sh_model[s][0] = 5'b01100;
      for (int r = 1; r < 4; r++) sh_model[s][r] = 5'd0;
    end
  endtask

  // Bus monitors: record every strobe and check setup/address/RW pairing.
  logic       prev_rom_a = 1'b1, prev_rom_b = 1'b1;
  logic [1:0] prev_addr_a = 2'd0, prev_addr_b = 2'd0;

  always @(negedge clk) begin
    if (!bus_a.nBUS_ROMSEL) begin
      qa.push_back('{cyc, bus_a.BUS_D7, bus_a.BUS_D0, bus_a.BUS_A14, bus_a.BUS_A13});
      check("a_setup_before_strobe", 32'(prev_rom_a), 32'd1);
      check("a_addr_stable", 32'({bus_a.BUS_A14, bus_a.BUS_A13}), 32'(prev_addr_a));
    end
    check("a_rw_with_romsel", 32'(bus_a.nBUS_RW), 32'(bus_a.nBUS_ROMSEL));
    prev_rom_a  = bus_a.nBUS_ROMSEL;
    prev_addr_a = {bus_a.BUS_A14, bus_a.BUS_A13};
  end

  always @(negedge clk) begin
    if (!bus_b.nBUS_ROMSEL) begin
      qb.push_back('{cyc, bus_b.BUS_D7, bus_b.BUS_D0, bus_b.BUS_A14, bus_b.BUS_A13});
      check("b_setup_before_strobe", 32'(prev_rom_b), 32'd1);
      check("b_addr_stable", 32'({bus_b.BUS_A14, bus_b.BUS_A13}), 32'(prev_addr_b));
    end
    check("b_rw_with_romsel", 32'(bus_b.nBUS_RW), 32'(bus_b.nBUS_ROMSEL));
    prev_rom_b  = bus_b.nBUS_ROMSEL;
    prev_addr_b = {bus_b.BUS_A14, bus_b.BUS_A13};
  end

  // One complete register load; entered and left on a falling edge.
  task automatic run_req(input bit sel, input logic [1:0] r, input logic [4:0] d,
                         input bit scramble, input bit hold, input bit expect_now);
    int         g    = sel ? 0 : 1;
    bit         rf   = sel ? 1'b0 : 1'b1;
    int         w    = rf ? 6 : 5;
    int         lat  = w * (2 + g);
    int         waited = 0;
    int         e0;
    int         n;
    int         prev_last = last_strobe[sel];
    logic [4:0] old_ctrl = sh_model[sel][0];
    strobe_t    ev[$];
    logic       exp_d0;
    int         bi;

    req_reg  = r;
    req_data = d;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    if (sel) qb.delete(); else qa.delete();
    while (!get_ready(sel) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (expect_now) check("b2b_handshake_wait", 32'(waited), 32'd0);
    if (waited >= 50) begin
      check("handshake_timeout", 32'(waited), 32'd0);
      valid_a = 1'b0;
      valid_b = 1'b0;
      return;
    end
    e0 = cyc + 1;
    @(negedge clk);
    if (!hold) begin
      if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    end
    check("busy_after_accept", 32'(get_busy(sel)), 32'd1);
    check("ready_low_after_accept", 32'(get_ready(sel)), 32'd0);

    n = 0;
    while (!get_done(sel) && n < 200) begin
      if (scramble) begin
        req_data = 5'($urandom);
        req_reg  = 2'($urandom);
      end
      if (rf && cyc == e0 + 2)
        check("sh_control_after_rst_write", 32'(get_sh(sel, 0)), 32'(old_ctrl | 5'b01100));
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(cyc - e0), 32'(lat));
    check("ready_with_done", 32'(get_ready(sel)), 32'd1);

    if (rf) sh_model[sel][0] = sh_model[sel][0] | 5'b01100;
    sh_model[sel][r] = d;
    for (int k = 0; k < 4; k++)
      check($sformatf("shadow%0d", k), 32'(get_sh(sel, k)), 32'(sh_model[sel][k]));

    if (sel) ev = qb; else ev = qa;
    check("strobe_count", 32'(ev.size()), 32'(w));
    for (int i = 0; i < ev.size() && i < w; i++) begin
      bi     = i - int'(rf);
      exp_d0 = (rf && i == 0) ? 1'b0 : d[bi];
      check($sformatf("strobe%0d_cycle", i), 32'(ev[i].cyc - e0), 32'(1 + i * (2 + g)));
      check($sformatf("strobe%0d_d7", i), 32'(ev[i].d7), 32'(rf && i == 0));
      check($sformatf("strobe%0d_d0", i), 32'(ev[i].d0), 32'(exp_d0));
      check($sformatf("strobe%0d_addr", i), 32'({ev[i].a14, ev[i].a13}), 32'(r));
    end
    if (expect_now && ev.size() > 0)
      check("b2b_idle_gap", 32'((ev[0].cyc - prev_last - 1) >= g), 32'd1);
    if (ev.size() > 0) last_strobe[sel] = ev[ev.size() - 1].cyc;

    $display("txn dut=%0d reg=%0d data=%b latency=%0d strobes=%0d", sel, r, d, cyc - e0, ev.size());
    if (!hold) begin
      @(negedge clk);
      check("done_one_cycle", 32'(get_done(sel)), 32'd0);
      check("busy_idle", 32'(get_busy(sel)), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    int dones;
    model_reset();
    last_strobe[0] = 0;
    last_strobe[1] = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_romsel", 32'(bus_a.nBUS_ROMSEL), 32'd1);
    check("rst_rw", 32'(bus_a.nBUS_RW), 32'd1);
    check("rst_d0_d7", 32'({bus_a.BUS_D0, bus_a.BUS_D7}), 32'd0);
    check("rst_addr", 32'({bus_a.BUS_A14, bus_a.BUS_A13}), 32'd0);
    check("rst_busy_done", 32'({bus_a.BUSY, bus_a.DONE}), 32'd0);
    check("rst_ready", 32'(bus_a.REQ_READY), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_shadow%0d", k), 32'(get_sh(1'b0, k)), 32'(sh_model[0][k]));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_a.REQ_READY), 32'd1);
    check("post_rst_busy", 32'(bus_a.BUSY), 32'd0);
    check("post_rst_romsel", 32'(bus_a.nBUS_ROMSEL), 32'd1);

    // Directed loads.
    run_req(1'b0, 2'b11, 5'b10110, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 2'b00, 5'b00010, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 2'b00, 5'b10010, 1'b0, 1'b0, 1'b0);
    check("idle_dut_no_bus_activity", 32'(qb.size()), 32'd0);
    run_req(1'b1, 2'b10, 5'b00001, 1'b0, 1'b0, 1'b0);

    // Back-to-back CHR0 loads with REQ_VALID held high.
    run_req(1'b0, 2'b01, 5'b11001, 1'b0, 1'b1, 1'b0);
    run_req(1'b0, 2'b01, 5'b00111, 1'b0, 1'b0, 1'b1);
    run_req(1'b1, 2'b01, 5'b01010, 1'b0, 1'b1, 1'b0);
    run_req(1'b1, 2'b01, 5'b10101, 1'b0, 1'b0, 1'b1);

    // Request inputs scrambled after acceptance.
    run_req(1'b0, 2'b10, 5'b01101, 1'b1, 1'b0, 1'b0);
    run_req(1'b1, 2'b11, 5'b11100, 1'b1, 1'b0, 1'b0);

    // Random loads.
    for (int t = 0; t < 10; t++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Reset during the third data strobe of DUT A.
    req_reg  = 2'b11;
    req_data = 5'b11111;
    valid_a  = 1'b1;
    cnt = 0;
    while (!bus_a.REQ_READY && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    valid_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (!bus_a.nBUS_ROMSEL) cnt++;
    end
    check("mid_rst_reached_strobe", 32'(cnt), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_romsel", 32'(bus_a.nBUS_ROMSEL), 32'd1);
    check("mid_rst_ready", 32'(bus_a.REQ_READY), 32'd0);
    check("mid_rst_busy_done", 32'({bus_a.BUSY, bus_a.DONE}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_a.DONE) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("mid_rst_shadow%0d", k), 32'(get_sh(1'b0, k)), 32'(sh_model[0][k]));
    run_req(1'b0, 2'b11, 5'b01011, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmc1_write_sequencer.md
# mmc1_write_sequencer

Bus-master sequencer that loads one MMC1 register per request. It converts a parallel 5-bit register write into the MMC1 serial protocol: an optional D7 shift-register reset write, then five D0 writes, LSB first, with address lines A14/A13 selecting the target register on every write. It sits between the cartridge loader/test host and the MMC1 CPU-side pins. It also keeps shadow copies of the four MMC1 registers for readback and debug.

## Interface
Parameters:
- GAP_CYCLES, 1, number of idle cycles after every strobe (0..15). Keeps consecutive writes from landing on adjacent cycles.
- RESET_FIRST, 1, when 1 each request starts with a D7=1 reset write; when 0 only the five data writes are issued.

Ports:
- CPU_M2  in  1  clock; all state updates on the rising edge.
- nRESET  in  1  reset, synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted on an edge where REQ_VALID && REQ_READY.
- REQ_REG  in  2  target register: 00 control, 01 CHR bank 0, 10 CHR bank 1, 11 PRG bank.
- REQ_DATA  in  5  value to load.
- BUS_A14, BUS_A13  out  1 each  register select, driven from the latched REQ_REG.
- BUS_D0  out  1  serial data bit.
- BUS_D7  out  1  shift-register reset bit.
- nBUS_ROMSEL  out  1  active-low cartridge select strobe.
- nBUS_RW  out  1  low means write.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.
- SH_CONTROL, SH_CHR0, SH_CHR1, SH_PRG  out  5 each  shadow registers.

## Operation
- States: IDLE, RST_SETUP, RST_STROBE, BIT_SETUP, BIT_STROBE, GAP.
- Internal counters: a 3-bit bit index (0..4) and a 4-bit gap counter.
- IDLE: REQ_READY=1, BUSY=0, bus released.
  - On handshake, latch REQ_REG and REQ_DATA and clear the bit index.
  - Go to RST_SETUP if RESET_FIRST=1, else to BIT_SETUP.
- RST_SETUP: D7=1, address driven, nBUS_ROMSEL=1, nBUS_RW=1. Next state RST_STROBE.
- RST_STROBE: D7=1, nBUS_ROMSEL=0, nBUS_RW=0. Leaving this state ORs SH_CONTROL with 01100, mirroring the MMC1 reset-write behaviour.
- BIT_SETUP: D7=0, D0=data[index], strobes high. Next state BIT_STROBE.
- BIT_STROBE: D0 held, nBUS_ROMSEL=0, nBUS_RW=0.
- After any strobe the block enters GAP for GAP_CYCLES cycles; with GAP_CYCLES=0, GAP is skipped. GAP drives strobes high, D7=0 and D0=0.
  - After the reset write, continue to BIT_SETUP.
  - After a bit write with index<4, increment the index and continue to BIT_SETUP.
  - After the bit-4 write, go to IDLE.
- Completion:
  - On the edge entering IDLE from the final write: write the latched data into the shadow register chosen by the latched REQ_REG, and assert DONE for exactly one cycle.
  - REQ_READY reasserts in that same cycle, so a new request can be accepted on the following edge.
- Address lines stay stable from the first SETUP through the final GAP and never change while a strobe is low.
- REQ_DATA and REQ_REG changes after acceptance are ignored.
- BUSY = !REQ_READY outside reset.

## Timing
- Reset values, while nRESET=0 and on the first cycle after it releases:
  - nBUS_ROMSEL=1, nBUS_RW=1, BUS_D0=0, BUS_D7=0, BUS_A14=0, BUS_A13=0.
  - BUSY=0, DONE=0.
  - REQ_READY=0 while nRESET is low, 1 afterwards.
  - SH_CONTROL=01100, SH_CHR0=00000, SH_CHR1=00000, SH_PRG=00000, matching MMC1 power-on.
- All outputs are registered.
- Cycles per bus write: 2 + GAP_CYCLES.
- Handshake edge E0 → DONE-high cycle begins at edge E0 + W·(2+GAP_CYCLES), with W=6 (RESET_FIRST=1) or W=5 (RESET_FIRST=0). Defaults give 18 cycles.
- Strobe-low width is exactly 1 cycle. Each strobe is preceded by at least 1 setup cycle with strobes high.
- Reset mid-sequence: on the next edge the block returns to IDLE and releases the bus, DONE is not asserted, and the shadows return to their reset values. The MMC1 shift register may be left partial; a following request with RESET_FIRST=1 recovers it.
- REQ_VALID held low in IDLE: the block stays idle with no bus activity.

## Test plan
- Defaults; load PRG with REQ_REG=11, REQ_DATA=10110 → one D7 strobe, then D0 strobes 0,1,1,0,1. A14=A13=1 throughout. DONE at E0+18. SH_PRG=10110.
- Control load 10010 with RESET_FIRST=1 → SH_CONTROL reads 01110 after the reset strobe, then 10010 at DONE.
- GAP_CYCLES=0, RESET_FIRST=0; CHR1 load 00001 → 5 strobes at 2-cycle spacing, A14=1, A13=0, DONE at E0+10, SH_CHR1=00001.
- Back-to-back: REQ_VALID held high with two CHR0 requests → second handshake lands on the edge after DONE, and at least GAP_CYCLES idle cycles separate the two strobe trains.
- nRESET low during the third data strobe → next edge gives nBUS_ROMSEL=1 and REQ_READY=0. After release: SH_* at reset values, no DONE pulse.
- Handshake followed by REQ_DATA changing on every cycle → serialized bits equal the value latched at the handshake.
